// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between an instruction
// fetch port and a data port. Data normally wins arbitration; a pending
// fetch is forced through after STARVE_LIM consecutive data grants.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  // data port
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  // stall indications
  output logic          if_stall,
  output logic          dm_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t        state, next_state;
  logic          grant_fetch, grant_data;
  logic [3:0]    starve_cnt;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;

  // Arbitration and next-state decode; grants are only issued from IDLE,
  // which produces the one-cycle bubble between back-to-back accesses.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    next_state  = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_req && !(if_req && (starve_cnt == LIM))) begin
          grant_data = 1'b1;
          next_state = DATA;
        end else if (if_req) begin
          grant_fetch = 1'b1;
          next_state  = FETCH;
        end
      end
      FETCH, DATA: begin
        if (mem_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight access without an ack.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Latch the winner's request so the memory sees it stable for the whole access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_data) begin
      addr_q  <= dm_addr;
      we_q    <= dm_we;
      wdata_q <= dm_wdata;
    end else if (grant_fetch) begin
      addr_q  <= if_addr;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end
  end

  // Count data grants that bypassed a waiting fetch; a fetch grant clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_fetch) begin
      starve_cnt <= '0;
    end else if (grant_data && if_req && (starve_cnt != LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Memory-side and requester-side outputs decode straight from the state,
  // so reset forces them inactive without waiting for a clock edge.
  always_comb begin
    mem_en    = (state != IDLE);
    mem_we    = (state == DATA) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ack    = (state == FETCH) && mem_ready;
    dm_ack    = (state == DATA) && mem_ready;
    if_rdata  = if_ack ? mem_rdata : '0;
    dm_rdata  = dm_ack ? mem_rdata : '0;
    if_stall  = if_req && !if_ack;
    dm_stall  = dm_req && !dm_ack;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes the
// expected completions in order; a monitor pops and compares on each ack.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, dm_ack, mem_en, mem_we, mem_ready, if_stall, dm_stall;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cur;
  int   n_vec = 0;
  int   n_err = 0;
  int   wait_states = 0;
  int   acc_cnt;
  int   lat;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .if_stall(if_stall), .dm_stall(dm_stall)
  );

  always #5 clk = ~clk;

  // Memory model: one fixed word, otherwise the upper half of the address inverted.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h40) return 32'h0050_0093;
    return a ^ 32'hFFFF_0000;
  endfunction

  assign mem_rdata = mem_model(mem_addr);
  assign mem_ready = mem_en && (acc_cnt == wait_states);

  always @(posedge clk or negedge reset) begin
    if (!reset)                    acc_cnt <= 0;
    else if (mem_en && !mem_ready) acc_cnt <= acc_cnt + 1;
    else                           acc_cnt <= 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no ack within budget", name);
  endtask

  function automatic void push(input logic d, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input int c);
    exp_t e;
    e.is_data = d; e.we = w; e.addr = a; e.wdata = wd; e.rdata = rd; e.cycles = c;
    exp_q.push_back(e);
  endfunction

  // Issue a fetch, hold it until if_ack, drop it just after the ack edge.
  task automatic fetch_req(input logic [31:0] a, output int n);
    if_req = 1'b1; if_addr = a; n = 0;
    while (1) begin
      @(negedge clk); n++;
      if (if_ack) break;
      if (n > 200) begin timeout("fetch_ack"); break; end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  // Issue a data access, hold it until dm_ack, drop it just after the ack edge.
  task automatic data_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          output int n);
    dm_req = 1'b1; dm_we = w; dm_addr = a; dm_wdata = wd; n = 0;
    while (1) begin
      @(negedge clk); n++;
      if (dm_ack) break;
      if (n > 200) begin timeout("data_ack"); break; end
    end
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) timeout("drain");
    @(posedge clk); #1;
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each ack.
  initial begin : monitor
    bit in_acc   = 0;
    bit prev_ack = 0;
    int cyc      = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_acc = 0; prev_ack = 0;
      end else begin
        check("if_rdata_idle", if_ack ? 32'h0 : if_rdata, 32'h0);
        check("dm_rdata_idle", dm_ack ? 32'h0 : dm_rdata, 32'h0);
        check("if_stall", if_stall, if_req & ~if_ack);
        check("dm_stall", dm_stall, dm_req & ~dm_ack);
        if (prev_ack) check("bubble_mem_en", mem_en, 1'b0);
        if (mem_en) begin
          if (!in_acc) begin
            in_acc = 1; cyc = 1;
            cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
          end else begin
            cyc++;
            check("hold_addr", mem_addr, cap_addr);
            check("hold_we", mem_we, cap_we);
            check("hold_wdata", mem_wdata, cap_wdata);
          end
        end else begin
          in_acc = 0;
        end
        if (if_ack || dm_ack) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_ack: if_ack=%0b dm_ack=%0b addr=%0h", if_ack, dm_ack, mem_addr);
          end else begin
            e_cur = exp_q.pop_front();
            check("ack_exclusive", if_ack & dm_ack, 1'b0);
            check("ack_port", dm_ack, e_cur.is_data);
            check("acc_addr", mem_addr, e_cur.addr);
            check("acc_we", mem_we, e_cur.we);
            if (e_cur.is_data && e_cur.we) check("acc_wdata", mem_wdata, e_cur.wdata);
            check("acc_rdata", e_cur.is_data ? dm_rdata : if_rdata, e_cur.rdata);
            check("acc_cycles", cyc, e_cur.cycles);
          end
          in_acc = 0;
        end
        prev_ack = if_ack || dm_ack;
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    // Reset state, asserted from time zero.
    #12;
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_acks", {if_ack, dm_ack}, 2'b00);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Single fetch, zero wait: ack in the cycle after the request is sampled.
    wait_states = 0;
    push(1'b0, 1'b0, 32'h40, 32'h0, 32'h0050_0093, 1);
    fetch_req(32'h40, lat);
    check("fetch_latency", lat, 2);

    // Store with three wait states: four access cycles, one ack.
    wait_states = 3;
    push(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_0100, 4);
    data_req(1'b1, 32'h100, 32'hDEAD_BEEF, lat);
    check("store_latency", lat, 5);

    // Load with one wait state.
    wait_states = 1;
    push(1'b1, 1'b0, 32'h204, 32'h0, 32'hFFFF_0204, 2);
    data_req(1'b0, 32'h204, 32'h0, lat);

    // Simultaneous requests: data first, fetch after the bubble.
    wait_states = 0;
    push(1'b1, 1'b0, 32'h300, 32'h0, 32'hFFFF_0300, 1);
    push(1'b0, 1'b0, 32'h44, 32'h0, 32'hFFFF_0044, 1);
    fork
      begin int n; data_req(1'b0, 32'h300, 32'h0, n); end
      begin int n; fetch_req(32'h44, n); check("fetch_after_data", n, 4); end
    join

    // Starvation: four data grants, then the forced fetch, then data resumes.
    for (int i = 0; i < 4; i++)
      push(1'b1, 1'b0, 32'h400 + 32'(4 * i), 32'h0, 32'hFFFF_0400 + 32'(4 * i), 1);
    push(1'b0, 1'b0, 32'h80, 32'h0, 32'hFFFF_0080, 1);
    push(1'b1, 1'b0, 32'h410, 32'h0, 32'hFFFF_0410, 1);
    fork
      begin int n; fetch_req(32'h80, n); end
      begin
        for (int i = 0; i < 5; i++) begin
          int n;
          data_req(1'b0, 32'h400 + 32'(4 * i), 32'h0, n);
        end
      end
    join
    check("starve_cnt_cleared", dut.starve_cnt, 4'd0);

    // Request dropped right after its grant: access still completes with the latched values.
    wait_states = 2;
    push(1'b1, 1'b1, 32'h500, 32'h1234_5678, 32'hFFFF_0500, 3);
    dm_we = 1'b1; dm_addr = 32'h500; dm_wdata = 32'h1234_5678; dm_req = 1'b1;
    @(posedge clk); #1;
    dm_req = 1'b0; dm_addr = 32'hBAD; dm_wdata = 32'h0; dm_we = 1'b0;
    wait_drain();

    // Reset mid-access: outputs drop at once, no ack, data wins after release.
    wait_states = 1000;
    dm_we = 1'b0; dm_addr = 32'h600; dm_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_abort_mem_en", mem_en, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_mem_en", mem_en, 1'b0);
    check("abort_mem_we", mem_we, 1'b0);
    check("abort_acks", {if_ack, dm_ack}, 2'b00);
    check("abort_mem_addr", mem_addr, 32'h0);
    if_req = 1'b1; if_addr = 32'h48;
    @(negedge clk); wait_states = 0;
    push(1'b1, 1'b0, 32'h600, 32'h0, 32'hFFFF_0600, 1);
    push(1'b0, 1'b0, 32'h48, 32'h0, 32'hFFFF_0048, 1);
    @(negedge clk); reset = 1'b1;
    fork
      begin int n; data_req(1'b0, 32'h600, 32'h0, n); end
      begin int n; fetch_req(32'h48, n); end
    join

    // Idle hold: nothing requested for ten cycles.
    repeat (10) begin
      @(negedge clk);
      check("idle_mem_en", mem_en, 1'b0);
      check("idle_acks", {if_ack, dm_ack}, 2'b00);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: AW, 32, address width in bits.
REQ-002 Parameter: DW, 32, data width in bits.
REQ-003 Parameter: STARVE_LIM, 4, consecutive data grants with fetch pending before fetch is forced (range 1-15).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port list (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- if_req, in, 1, fetch request; held high until if_ack.
- if_addr, in, AW, fetch address.
- if_ack, out, 1, one-cycle fetch completion pulse.
- if_rdata, out, DW, fetch data; valid only while if_ack=1.
- dm_req, in, 1, data request; held high until dm_ack.
- dm_we, in, 1, 1=store, 0=load.
- dm_addr, in, AW, data address.
- dm_wdata, in, DW, store data.
- dm_ack, out, 1, one-cycle data completion pulse.
- dm_rdata, out, DW, load data; valid only while dm_ack=1.
- mem_en, out, 1, memory access active.
- mem_we, out, 1, memory write strobe.
- mem_addr, out, AW, memory address.
- mem_wdata, out, DW, memory write data.
- mem_rdata, in, DW, memory read data.
- mem_ready, in, 1, memory completes the current access this cycle.
- if_stall, out, 1, equals if_req & ~if_ack.
- dm_stall, out, 1, equals dm_req & ~dm_ack.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, FETCH, DATA.
REQ-007 In IDLE with no request, the FSM SHALL remain in IDLE with mem_en=0.
REQ-008 In IDLE, arbitration SHALL grant DATA if dm_req=1, unless if_req=1 and starve_cnt==STARVE_LIM; in that case it SHALL grant FETCH.
REQ-009 In IDLE with only if_req=1, the FSM SHALL grant FETCH.
REQ-010 On grant, the winner's address, we, and wdata SHALL be latched into registers that drive mem_addr/mem_we/mem_wdata.
- Fetch SHALL force mem_we=0.
- Latched values SHALL hold constant until the access ends.
REQ-011 In FETCH or DATA, mem_en SHALL be 1; with mem_ready=0 the FSM SHALL stay in the state (unbounded wait).
REQ-012 In FETCH or DATA with mem_ready=1:
- the matching ack SHALL pulse high for that cycle;
- the matching rdata SHALL equal mem_rdata combinationally;
- the FSM SHALL return to IDLE.
REQ-013 Minimum latency, request sampled in IDLE at cycle N with zero-wait memory: ack at cycle N+1; the next grant no earlier than N+2 (one IDLE bubble).
REQ-014 starve_cnt (4 bits):
- SHALL increment, saturating at STARVE_LIM, on each DATA grant made while if_req=1;
- SHALL clear to 0 on every FETCH grant;
- SHALL otherwise hold.
REQ-015 A request deasserted before its ack is a protocol violation; the in-flight access SHALL still complete and its ack SHALL still pulse.
REQ-016 if_ack and dm_ack SHALL never be high in the same cycle.
REQ-017 Whenever the matching ack is 0, if_rdata and dm_rdata SHALL be driven 0.

Reset
REQ-018 While reset=0, the following SHALL hold immediately, independent of clk:
- state=IDLE, starve_cnt=0, latched address/we/wdata=0;
- mem_en=0, mem_we=0, if_ack=0, dm_ack=0.
REQ-019 Reset asserted mid-access SHALL abort that access with no ack. After release, arbitration SHALL restart from IDLE on the first rising edge.

Verification
REQ-020 Single fetch, zero wait: if_req=1, if_addr=0x40, mem_ready=1, mem_rdata=0x00500093 -> mem_en=1 with mem_addr=0x40 and mem_we=0 at cycle 1; if_ack=1 with if_rdata=0x00500093 at cycle 1.
REQ-021 Store with 3 wait states: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, mem_ready low for 3 cycles -> mem_en/mem_we/mem_addr/mem_wdata stable for 4 cycles; dm_ack pulses once, in the 4th access cycle.
REQ-022 Simultaneous requests: if_req=dm_req=1, both held -> the DATA access completes first, then FETCH after one IDLE bubble.
REQ-023 Starvation with STARVE_LIM=4: if_req held, dm_req re-asserted immediately after every ack -> 4 data accesses, then 1 fetch, then starve_cnt=0 and data resumes.
REQ-024 Reset mid-access: reset=0 during DATA with mem_ready=0 -> mem_en=0 in the same cycle, no dm_ack; after release with both requests high, the first grant is DATA.
REQ-025 Idle hold: no requests for 10 cycles -> mem_en=0 and both acks 0 throughout.
